spi_link: RTL and testbench

- Self-contained SPI master plus SPI slave pair in one clock domain, wired back-to-back inside the block.
- The master serialises a byte from a valid/ready host port and captures the returned byte.
- The slave shifts out a preloaded byte and captures the master's byte.
- SPI lines are exposed as outputs for observation; the block is used as a link-level building block and as a self-checking SPI loopback for the accelerometer driver.

---
 rtl/spi_link_if.sv | 41 ++++
 rtl/spi_link.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_link.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_link_if.sv
// ---------------------------------------------------------------------------
// spi_link_if
// Bundles the host-side transfer handshake, the slave preload/capture bytes
// and the observable SPI lines of spi_link.
//   master modport : the host that issues transfers and observes the link
//   slave  modport : the spi_link block itself
// Signals:
//   i_Tx_Byte / i_Tx_Valid / o_Tx_Ready : host transmit handshake
//   o_Rx_Byte / o_Rx_Hold               : byte returned to the host + pulse
//   i_Slv_Tx_Byte                       : byte the slave answers with
//   o_Slv_Rx_Byte / o_Slv_Rx_Valid      : byte the slave captured + pulse
//   o_SPI_Clk / o_SPI_CSLow / o_SPI_Mosi / o_SPI_Miso : SPI wires
// ---------------------------------------------------------------------------
interface spi_link_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_Tx_Byte;
    logic                  i_Tx_Valid;
    logic                  o_Tx_Ready;
    logic [DATA_WIDTH-1:0] o_Rx_Byte;
    logic                  o_Rx_Hold;
    logic [DATA_WIDTH-1:0] i_Slv_Tx_Byte;
    logic [DATA_WIDTH-1:0] o_Slv_Rx_Byte;
    logic                  o_Slv_Rx_Valid;
    logic                  o_SPI_Clk;
    logic                  o_SPI_CSLow;
    logic                  o_SPI_Mosi;
    logic                  o_SPI_Miso;

    modport master (
        output i_Tx_Byte, i_Tx_Valid, i_Slv_Tx_Byte,
        input  o_Tx_Ready, o_Rx_Byte, o_Rx_Hold, o_Slv_Rx_Byte, o_Slv_Rx_Valid,
        input  o_SPI_Clk, o_SPI_CSLow, o_SPI_Mosi, o_SPI_Miso
    );

    modport slave (
        input  i_Tx_Byte, i_Tx_Valid, i_Slv_Tx_Byte,
        output o_Tx_Ready, o_Rx_Byte, o_Rx_Hold, o_Slv_Rx_Byte, o_Slv_Rx_Valid,
        output o_SPI_Clk, o_SPI_CSLow, o_SPI_Mosi, o_SPI_Miso
    );
endinterface

// File: rtl/spi_link.sv
// ---------------------------------------------------------------------------
// spi_link
// SPI master and SPI slave wired back-to-back in one clock domain.
// The master takes a byte from the valid/ready host port, frames it with
// chip select, shifts it out MSB first and captures the slave's answer.
// The slave detects edges of the (registered) SPI clock and chip select,
// returns a byte preloaded at CS falling and captures the master's byte.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : spi_link_if slave modport (handshake, bytes, SPI wires)
// ---------------------------------------------------------------------------
module spi_link #(
    parameter int CPOL              = 0,
    parameter int CPHA              = 0,
    parameter int DATA_WIDTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    spi_link_if.slave  bus
);
    localparam int CW = 16;
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_INACTIVE_CLKS - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          IDLE_LVL  = (CPOL != 0);
    // Leading edges sample in CPHA=0, trailing edges sample in CPHA=1.
    localparam logic          SAMPLE_ON_LEAD = (CPHA == 0);

    typedef enum logic [2:0] {M_IDLE, M_CS_SETUP, M_XFER, M_CS_HOLD, M_CS_GAP} m_state_t;
    typedef enum logic {S_IDLE, S_ACTIVE} s_state_t;

    // Master registers
    m_state_t              m_state, m_state_nxt;
    logic [CW-1:0]         m_cnt, m_cnt_nxt;
    logic [EW-1:0]         m_edges, m_edges_nxt;
    logic [DATA_WIDTH-1:0] m_tx_sr, m_tx_sr_nxt;
    logic [DATA_WIDTH-1:0] m_rx_sr, m_rx_sr_nxt;
    logic                  sclk, sclk_nxt;
    logic                  cs_n, cs_n_nxt;
    logic                  mosi, mosi_nxt;
    logic [DATA_WIDTH-1:0] rx_byte, rx_byte_nxt;
    logic                  rx_hold, rx_hold_nxt;

    // Slave registers
    s_state_t              s_state, s_state_nxt;
    logic                  s_sclk_q, s_cs_q;
    logic [DATA_WIDTH-1:0] s_tx_sr, s_tx_sr_nxt;
    logic [DATA_WIDTH-1:0] s_rx_sr, s_rx_sr_nxt;
    logic [BW-1:0]         s_bits, s_bits_nxt;
    logic                  s_miso, s_miso_nxt;
    logic [DATA_WIDTH-1:0] slv_rx_byte, slv_rx_byte_nxt;
    logic                  slv_rx_valid, slv_rx_valid_nxt;

    logic m_half_done;
    logic m_lead;
    logic miso;
    logic s_cs_fall, s_cs_rise, s_edge, s_lead;

    assign m_half_done = (m_cnt == HALF_LAST);
    // The edge about to be generated leaves the idle level when sclk is idle.
    assign m_lead      = (sclk == IDLE_LVL);
    // MISO is forced low whenever chip select is inactive.
    assign miso        = s_miso & ~cs_n;

    assign s_cs_fall = s_cs_q & ~cs_n;
    assign s_cs_rise = ~s_cs_q & cs_n;
    assign s_edge    = (sclk != s_sclk_q);
    assign s_lead    = (s_sclk_q == IDLE_LVL);

    assign bus.o_Tx_Ready     = (m_state == M_IDLE);
    assign bus.o_Rx_Byte      = rx_byte;
    assign bus.o_Rx_Hold      = rx_hold;
    assign bus.o_Slv_Rx_Byte  = slv_rx_byte;
    assign bus.o_Slv_Rx_Valid = slv_rx_valid;
    assign bus.o_SPI_Clk      = sclk;
    assign bus.o_SPI_CSLow    = cs_n;
    assign bus.o_SPI_Mosi     = mosi;
    assign bus.o_SPI_Miso     = miso;

    // ---------------- master next-state / outputs ----------------
    always_comb begin
        m_state_nxt = m_state;
        m_cnt_nxt   = m_cnt;
        m_edges_nxt = m_edges;
        m_tx_sr_nxt = m_tx_sr;
        m_rx_sr_nxt = m_rx_sr;
        sclk_nxt    = sclk;
        cs_n_nxt    = cs_n;
        mosi_nxt    = mosi;
        rx_byte_nxt = rx_byte;
        rx_hold_nxt = 1'b0;

        case (m_state)
            M_IDLE: begin
                if (bus.i_Tx_Valid) begin
                    m_state_nxt = M_CS_SETUP;
                    m_cnt_nxt   = '0;
                    cs_n_nxt    = 1'b0;
                    if (CPHA == 0) begin
                        // MSB goes out immediately; the shifter holds the rest.
                        mosi_nxt    = bus.i_Tx_Byte[DATA_WIDTH-1];
                        m_tx_sr_nxt = {bus.i_Tx_Byte[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        m_tx_sr_nxt = bus.i_Tx_Byte;
                    end
                end
            end
            M_CS_SETUP: begin
                if (m_half_done) begin
                    m_state_nxt = M_XFER;
                    m_cnt_nxt   = '0;
                    m_edges_nxt = '0;
                end else begin
                    m_cnt_nxt = m_cnt + CW'(1);
                end
            end
            M_XFER: begin
                if (m_half_done) begin
                    m_cnt_nxt   = '0;
                    sclk_nxt    = ~sclk;
                    m_edges_nxt = m_edges + EW'(1);
                    if (m_lead == SAMPLE_ON_LEAD) begin
                        m_rx_sr_nxt = {m_rx_sr[DATA_WIDTH-2:0], miso};
                    end else begin
                        mosi_nxt    = m_tx_sr[DATA_WIDTH-1];
                        m_tx_sr_nxt = {m_tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                    // Last edge brings sclk back to its idle level.
                    if (m_edges == EDGE_LAST) begin
                        m_state_nxt = M_CS_HOLD;
                    end
                end else begin
                    m_cnt_nxt = m_cnt + CW'(1);
                end
            end
            M_CS_HOLD: begin
                if (m_half_done) begin
                    m_state_nxt = M_CS_GAP;
                    m_cnt_nxt   = '0;
                    cs_n_nxt    = 1'b1;
                    rx_byte_nxt = m_rx_sr;
                    rx_hold_nxt = 1'b1;
                end else begin
                    m_cnt_nxt = m_cnt + CW'(1);
                end
            end
            M_CS_GAP: begin
                if (m_cnt == GAP_LAST) begin
                    m_state_nxt = M_IDLE;
                end else begin
                    m_cnt_nxt = m_cnt + CW'(1);
                end
            end
            default: m_state_nxt = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= M_IDLE;
            m_cnt   <= '0;
            m_edges <= '0;
            m_tx_sr <= '0;
            m_rx_sr <= '0;
            sclk    <= IDLE_LVL;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            rx_byte <= '0;
            rx_hold <= 1'b0;
        end else begin
            m_state <= m_state_nxt;
            m_cnt   <= m_cnt_nxt;
            m_edges <= m_edges_nxt;
            m_tx_sr <= m_tx_sr_nxt;
            m_rx_sr <= m_rx_sr_nxt;
            sclk    <= sclk_nxt;
            cs_n    <= cs_n_nxt;
            mosi    <= mosi_nxt;
            rx_byte <= rx_byte_nxt;
            rx_hold <= rx_hold_nxt;
        end
    end

    // ---------------- slave next-state / outputs ----------------
    // Edges are seen one clk after the master makes them; with at least two
    // clks per half bit the mirrored shift still lands before the next sample.
    always_comb begin
        s_state_nxt      = s_state;
        s_tx_sr_nxt      = s_tx_sr;
        s_rx_sr_nxt      = s_rx_sr;
        s_bits_nxt       = s_bits;
        s_miso_nxt       = s_miso;
        slv_rx_byte_nxt  = slv_rx_byte;
        slv_rx_valid_nxt = 1'b0;

        case (s_state)
            S_IDLE: begin
                if (s_cs_fall) begin
                    s_state_nxt = S_ACTIVE;
                    s_bits_nxt  = '0;
                    if (CPHA == 0) begin
                        s_miso_nxt  = bus.i_Slv_Tx_Byte[DATA_WIDTH-1];
                        s_tx_sr_nxt = {bus.i_Slv_Tx_Byte[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        s_miso_nxt  = 1'b0;
                        s_tx_sr_nxt = bus.i_Slv_Tx_Byte;
                    end
                end
            end
            S_ACTIVE: begin
                if (s_cs_rise) begin
                    // Any partially received byte is simply dropped.
                    s_state_nxt = S_IDLE;
                    s_miso_nxt  = 1'b0;
                end else if (s_edge) begin
                    if (s_lead == SAMPLE_ON_LEAD) begin
                        s_rx_sr_nxt = {s_rx_sr[DATA_WIDTH-2:0], mosi};
                        s_bits_nxt  = s_bits + BW'(1);
                        if (s_bits == BIT_LAST) begin
                            slv_rx_byte_nxt  = {s_rx_sr[DATA_WIDTH-2:0], mosi};
                            slv_rx_valid_nxt = 1'b1;
                        end
                    end else begin
                        s_miso_nxt  = s_tx_sr[DATA_WIDTH-1];
                        s_tx_sr_nxt = {s_tx_sr[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: s_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_state      <= S_IDLE;
            s_sclk_q     <= IDLE_LVL;
            s_cs_q       <= 1'b1;
            s_tx_sr      <= '0;
            s_rx_sr      <= '0;
            s_bits       <= '0;
            s_miso       <= 1'b0;
            slv_rx_byte  <= '0;
            slv_rx_valid <= 1'b0;
        end else begin
            s_state      <= s_state_nxt;
            s_sclk_q     <= sclk;
            s_cs_q       <= cs_n;
            s_tx_sr      <= s_tx_sr_nxt;
            s_rx_sr      <= s_rx_sr_nxt;
            s_bits       <= s_bits_nxt;
            s_miso       <= s_miso_nxt;
            slv_rx_byte  <= slv_rx_byte_nxt;
            slv_rx_valid <= slv_rx_valid_nxt;
        end
    end
endmodule

// File: tb/tb_spi_link.sv
// ---------------------------------------------------------------------------
// tb_spi_link
// Runs four spi_link instances, one per (CPOL,CPHA) mode, in lockstep from
// shared stimulus. A single monitor process holds the reference model: it
// tracks host readiness from transfer timing, queues the expected byte pair
// at each accept, and checks Rx pulses and the SPI wire activity per mode.
// ---------------------------------------------------------------------------
module tb_spi_link;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [7:0] slv_byte;
    bit         stim_done;

    always #5 clk = ~clk;

    logic       sclk_w [4];
    logic       csn_w  [4];
    logic       mosi_w [4];
    logic       miso_w [4];
    logic       rdy_w  [4];
    logic       rxh_w  [4];
    logic       svld_w [4];
    logic [7:0] rxb_w  [4];
    logic [7:0] srxb_w [4];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_link_if #(.DATA_WIDTH(8)) bus ();
        assign bus.i_Tx_Byte     = tx_byte;
        assign bus.i_Tx_Valid    = tx_valid;
        assign bus.i_Slv_Tx_Byte = slv_byte;
        assign sclk_w[g] = bus.o_SPI_Clk;
        assign csn_w[g]  = bus.o_SPI_CSLow;
        assign mosi_w[g] = bus.o_SPI_Mosi;
        assign miso_w[g] = bus.o_SPI_Miso;
        assign rdy_w[g]  = bus.o_Tx_Ready;
        assign rxh_w[g]  = bus.o_Rx_Hold;
        assign svld_w[g] = bus.o_Slv_Rx_Valid;
        assign rxb_w[g]  = bus.o_Rx_Byte;
        assign srxb_w[g] = bus.o_Slv_Rx_Byte;

        spi_link #(
            .CPOL(g / 2), .CPHA(g % 2), .DATA_WIDTH(8),
            .CLKS_PER_HALF_BIT(2), .CS_INACTIVE_CLKS(2)
        ) dut (
            .clk(clk),
            .reset(rst_n),
            .bus(bus)
        );
    end

    // ---------------- reference model / scoreboard ----------------
    typedef logic [15:0] pair_q_t[$];   // {master tx byte, slave tx byte}
    pair_q_t rx_q   [4];
    pair_q_t slv_q  [4];
    pair_q_t wire_q [4];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ready_at = 0;
    bit          model_rdy;
    logic        cp, ph, lead;
    logic [15:0] ent;
    logic [31:0] act_v, exp_v;
    logic        prev_csn [4];
    logic        prev_sclk[4];
    logic [7:0]  mosi_acc [4];
    logic [7:0]  miso_acc [4];
    int          n_edges  [4];
    int          n_samp   [4];
    int          low_len  [4];
    int          high_len [4];
    bit          rdy_seen [4];

    task automatic check(input bit ok, input string nm, input int m,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s (mode %0d): actual 0x%0h, required 0x%0h", nm, m, act, req);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int m = 0; m < 4; m++) begin
                cp    = (m >= 2);
                act_v = {9'd0, sclk_w[m], csn_w[m], mosi_w[m], miso_w[m], rdy_w[m],
                         rxh_w[m], svld_w[m], rxb_w[m], srxb_w[m]};
                exp_v = {9'd0, cp, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
                check(act_v == exp_v, "reset_values", m, act_v, exp_v);
                rx_q[m].delete();
                slv_q[m].delete();
                wire_q[m].delete();
                prev_csn[m]  = 1'b1;
                prev_sclk[m] = cp;
                high_len[m]  = 100;
                low_len[m]   = 0;
            end
            ready_at = 0;
        end else begin
            // Idle for 38 clks after each accept, then ready again.
            model_rdy = (cyc >= ready_at);
            for (int m = 0; m < 4; m++)
                check(rdy_w[m] == model_rdy, "tx_ready", m, rdy_w[m], model_rdy);
            if (model_rdy && tx_valid) begin
                for (int m = 0; m < 4; m++) begin
                    rx_q[m].push_back({tx_byte, slv_byte});
                    slv_q[m].push_back({tx_byte, slv_byte});
                    wire_q[m].push_back({tx_byte, slv_byte});
                end
                ready_at = cyc + 39;
            end
            for (int m = 0; m < 4; m++) begin
                cp = (m >= 2);
                ph = (m % 2 == 1);
                if (rxh_w[m]) begin
                    check(rx_q[m].size() != 0, "rx_hold_expected", m, rx_q[m].size(), 1);
                    if (rx_q[m].size() != 0) begin
                        ent = rx_q[m].pop_front();
                        check(rxb_w[m] == ent[7:0], "rx_byte", m, rxb_w[m], ent[7:0]);
                    end
                end
                if (svld_w[m]) begin
                    check(slv_q[m].size() != 0, "slv_valid_expected", m, slv_q[m].size(), 1);
                    if (slv_q[m].size() != 0) begin
                        ent = slv_q[m].pop_front();
                        check(srxb_w[m] == ent[15:8], "slv_rx_byte", m, srxb_w[m], ent[15:8]);
                    end
                end
                if (!csn_w[m]) begin
                    if (prev_csn[m]) begin
                        check(high_len[m] >= 2, "cs_gap", m, high_len[m], 2);
                        check(sclk_w[m] == cp, "sclk_at_cs_fall", m, sclk_w[m], cp);
                        low_len[m]  = 0;
                        n_edges[m]  = 0;
                        n_samp[m]   = 0;
                        rdy_seen[m] = 1'b0;
                        mosi_acc[m] = 8'h00;
                        miso_acc[m] = 8'h00;
                    end
                    low_len[m]++;
                    if (rdy_w[m]) rdy_seen[m] = 1'b1;
                    if (sclk_w[m] != prev_sclk[m]) begin
                        lead = (prev_sclk[m] == cp);
                        n_edges[m]++;
                        if (lead == !ph) begin
                            n_samp[m]++;
                            mosi_acc[m] = {mosi_acc[m][6:0], mosi_w[m]};
                            miso_acc[m] = {miso_acc[m][6:0], miso_w[m]};
                        end
                    end
                end else begin
                    if (!prev_csn[m]) begin
                        check(wire_q[m].size() != 0, "cs_frame_expected", m, wire_q[m].size(), 1);
                        if (wire_q[m].size() != 0) begin
                            ent = wire_q[m].pop_front();
                            check(mosi_acc[m] == ent[15:8], "mosi_bits", m, mosi_acc[m], ent[15:8]);
                            check(miso_acc[m] == ent[7:0], "miso_bits", m, miso_acc[m], ent[7:0]);
                        end
                        check(low_len[m] == 36, "cs_low_clks", m, low_len[m], 36);
                        check(n_edges[m] == 16, "spi_edges", m, n_edges[m], 16);
                        check(n_samp[m] == 8, "sample_edges", m, n_samp[m], 8);
                        check(!rdy_seen[m], "ready_during_xfer", m, rdy_seen[m], 0);
                        check(sclk_w[m] == cp, "sclk_idle", m, sclk_w[m], cp);
                        high_len[m] = 0;
                    end
                    high_len[m]++;
                end
                prev_csn[m]  = csn_w[m];
                prev_sclk[m] = sclk_w[m];
            end
        end

        if (stim_done) begin
            for (int m = 0; m < 4; m++) begin
                check(rx_q[m].size() == 0, "rx_pending", m, rx_q[m].size(), 0);
                check(slv_q[m].size() == 0, "slv_pending", m, slv_q[m].size(), 0);
                check(wire_q[m].size() == 0, "frame_pending", m, wire_q[m].size(), 0);
            end
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int hold;
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_byte   = 8'h00;
        slv_byte  = 8'h3C;
        stim_done = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(3);

        // single A5 / 3C exchange
        tx_byte = 8'hA5; tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tick(45);

        // valid held: back-to-back 5A transfers
        tx_byte = 8'h5A; tx_valid = 1'b1; tick(450);
        tx_valid = 1'b0; tick(45);

        // valid pulses while busy are ignored
        tx_byte = 8'hC3; tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tx_byte = 8'hFF; tick(10);
        tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tick(15);
        tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tick(45);

        // reset after four bits of a transfer
        tx_byte = 8'hA5; tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tick(19);
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1; tick(3);
        tx_byte = 8'hA5; tx_valid = 1'b1; tick(1);
        tx_valid = 1'b0; tick(45);

        // randomized bytes and valid hold lengths
        for (int i = 0; i < 25; i++) begin
            slv_byte = 8'($urandom);
            tx_byte  = 8'($urandom);
            tx_valid = 1'b1;
            hold     = int'($urandom_range(1, 90));
            for (int k = 0; k < hold; k++) begin
                tick(1);
                tx_byte = 8'($urandom);
            end
            tx_valid = 1'b0;
            tick(int'($urandom_range(40, 55)));
        end

        stim_done = 1'b1;
        tick(3);
    end
endmodule
